// File: rtl/router_pkg.sv
// Shared types and defaults for the N-channel router control FSM.
package router_pkg;

  typedef enum logic [3:0] {
    DA   = 4'd0,
    LFD  = 4'd1,
    LD   = 4'd2,
    WTE  = 4'd3,
    CPE  = 4'd4,
    LP   = 4'd5,
    FFS  = 4'd6,
    LAF  = 4'd7,
    DROP = 4'd8
  } state_e;

  localparam int N_DEFAULT          = 3;
  localparam int WAIT_LIMIT_DEFAULT = 16;

  // Header address width; a two-channel router still needs one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Bounded cycle counter for the wait-till-empty state; expired marks the last allowed cycle.
module router_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xN packet router: header decode, payload load, full stall,
// parity check, plus address and wait-timeout drops.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int ADDR_W     = addr_w(N),
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [N-1:0]      fifo_empty,
  input  logic [N-1:0]      soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [ADDR_W-1:0] dest_sel,
  output logic              wait_timeout
);

  state_e state, next_state;
  logic   addr_bad;
  logic   soft_hit;
  logic   wait_expired;

  assign addr_bad = (32'(data_in) >= 32'(N));
  // DROP keeps dest_sel possibly out of range, so soft reset is only honoured mid-packet.
  assign soft_hit = (state != DA) && (state != DROP) && soft_reset[dest_sel];

  generate
    if (WAIT_LIMIT != 0) begin : g_timer
      router_wait_timer #(
        .LIMIT (WAIT_LIMIT)
      ) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state != WTE),
        .enable  (state == WTE),
        .expired (wait_expired)
      );
    end else begin : g_no_timer
      assign wait_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    next_state = state;
    if (soft_hit) begin
      next_state = DA;
    end else begin
      case (state)
        DA: begin
          if (pkt_valid) begin
            if (addr_bad)                 next_state = DROP;
            else if (fifo_empty[data_in]) next_state = LFD;
            else                          next_state = WTE;
          end
        end
        LFD: next_state = LD;
        LD: begin
          if (fifo_full)       next_state = FFS;
          else if (!pkt_valid) next_state = LP;
        end
        FFS: if (!fifo_full) next_state = LAF;
        LAF: begin
          if (parity_done)        next_state = DA;
          else if (low_pkt_valid) next_state = LP;
          else                    next_state = LD;
        end
        LP:  next_state = CPE;
        CPE: next_state = fifo_full ? FFS : DA;
        // Channel draining in the last allowed cycle still wins over the timeout.
        WTE: begin
          if (fifo_empty[dest_sel]) next_state = LFD;
          else if (wait_expired)    next_state = DROP;
        end
        DROP: if (!pkt_valid) next_state = DA;
        default: next_state = DA;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= DA;
      dest_sel     <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state        <= next_state;
      wait_timeout <= (state == WTE) && (next_state == DROP);
      if (state == DA && pkt_valid) dest_sel <= data_in;
    end
  end

  assign detect_add    = (state == DA);
  assign lfd_state     = (state == LFD);
  assign ld_state      = (state == LD);
  assign laf_state     = (state == LAF);
  assign full_state    = (state == FFS);
  assign rst_int_reg   = (state == CPE);
  assign drop_state    = (state == DROP);
  assign write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
  assign busy          = (state == LFD) || (state == WTE) || (state == FFS) ||
                         (state == LAF) || (state == LP)  || (state == CPE);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: directed vector table, async-reset sequence, random run vs model.
module tb_router_fsm_nch;

  localparam int N  = 3;
  localparam int WL = 4;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          pkt_valid = 1'b0;
  logic [AW-1:0] data_in = '0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  fifo_empty = '0;
  logic [N-1:0]  soft_reset = '0;
  logic          parity_done = 1'b0;
  logic          low_pkt_valid = 1'b0;
  logic          detect_add, lfd_state, ld_state, laf_state, full_state;
  logic          rst_int_reg, write_enb_reg, busy, drop_state, wait_timeout;
  logic [AW-1:0] dest_sel;

  int n_checks = 0;
  int n_fail   = 0;

  router_fsm_nch #(.N(N), .WAIT_LIMIT(WL)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .drop_state    (drop_state),
    .dest_sel      (dest_sel),
    .wait_timeout  (wait_timeout)
  );

  always #5 clock = ~clock;

  typedef enum int {S_IDLE, S_LFD, S_LD, S_WTE, S_CPE, S_LP, S_FFS, S_LAF, S_DROP} ms_e;

  // Behavioural model of the controller's observable phase
  ms_e m_st;
  int  m_dest;
  int  m_wait;
  bit  m_to;

  task automatic model_reset();
    m_st = S_IDLE; m_dest = 0; m_wait = 0; m_to = 0;
  endtask

  task automatic model_step();
    ms_e nx;
    nx = m_st;
    m_to = 0;
    if (m_st != S_IDLE && m_st != S_DROP && m_dest < N && soft_reset[m_dest]) begin
      nx = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE: if (pkt_valid) begin
          m_dest = int'(data_in);
          if (m_dest >= N)              nx = S_DROP;
          else if (fifo_empty[m_dest])  nx = S_LFD;
          else                          nx = S_WTE;
        end
        S_LFD: nx = S_LD;
        S_LD:  nx = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
        S_FFS: nx = fifo_full ? S_FFS : S_LAF;
        S_LAF: nx = parity_done ? S_IDLE : (low_pkt_valid ? S_LP : S_LD);
        S_LP:  nx = S_CPE;
        S_CPE: nx = fifo_full ? S_FFS : S_IDLE;
        S_WTE: begin
          if (fifo_empty[m_dest]) nx = S_LFD;
          else if (WL != 0 && m_wait == WL - 1) begin nx = S_DROP; m_to = 1; end
          else m_wait = m_wait + 1;
        end
        S_DROP: nx = pkt_valid ? S_DROP : S_IDLE;
        default: nx = S_IDLE;
      endcase
    end
    if (nx == S_WTE && m_st != S_WTE) m_wait = 0;
    m_st = nx;
  endtask

  function automatic logic [8:0] flags_of(input ms_e s);
    logic we, bz;
    we = (s == S_LD) || (s == S_LP) || (s == S_LAF);
    bz = (s == S_LFD) || (s == S_WTE) || (s == S_FFS) || (s == S_LAF) ||
         (s == S_LP) || (s == S_CPE);
    return {s == S_IDLE, s == S_LFD, s == S_LD, s == S_LAF, s == S_FFS,
            s == S_CPE, we, bz, s == S_DROP};
  endfunction

  task automatic check(input string name, input ms_e es, input logic eto, input int edest);
    logic [9:0] act, exp;
    logic [AW-1:0] ed;
    act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_state, wait_timeout};
    exp = {flags_of(es), eto};
    ed  = AW'(edest);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s flags got=%b expected=%b (state %s)", name, act, exp, es.name());
    end
    n_checks++;
    if (dest_sel !== ed) begin
      n_fail++;
      $display("FAIL %s dest_sel got=%0d expected=%0d", name, dest_sel, ed);
    end
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clock); #1;
    check(name, m_st, m_to, m_dest);
  endtask

  typedef struct {
    logic pv; logic [1:0] din; logic ff; logic [2:0] fe; logic [2:0] sr;
    logic pd; logic lpv; ms_e st; logic to; int dest;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pv, input logic [1:0] din, input logic ff,
                              input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                              input logic lpv, input ms_e st, input logic to, input int dest);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.st = st; v.to = to; v.dest = dest;
    return v;
  endfunction

  initial begin
    // Normal packet to channel 1
    tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LFD,  0, 1));
    tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LD,   0, 1));
    tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LD,   0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_LP,   0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_CPE,  0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_IDLE, 0, 1));
    // Full stall for three cycles, resume into parity load
    tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LFD,  0, 1));
    tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LD,   0, 1));
    tbl.push_back(mk(1, 1, 1, 3'b010, 0, 0, 0, S_FFS,  0, 1));
    tbl.push_back(mk(1, 1, 1, 3'b010, 0, 0, 0, S_FFS,  0, 1));
    tbl.push_back(mk(1, 1, 1, 3'b010, 0, 0, 0, S_FFS,  0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 1, S_LAF,  0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 1, S_LP,   0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_CPE,  0, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_IDLE, 0, 1));
    // Out-of-range address drop
    tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(0, 3, 0, 3'b111, 0, 0, 0, S_IDLE, 0, 3));
    // Wait timeout after four cycles
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_DROP, 1, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_DROP, 0, 2));
    tbl.push_back(mk(0, 2, 0, 3'b000, 0, 0, 0, S_IDLE, 0, 2));
    // Empty in the last wait cycle beats the timeout; then soft resets in LD
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b100, 0, 0, 0, S_LFD,  0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b100, 0, 0, 0, S_LD,   0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b100, 3'b001, 0, 0, S_LD,   0, 2));
    tbl.push_back(mk(1, 2, 0, 3'b100, 3'b100, 0, 0, S_IDLE, 0, 2));
    // Soft reset has no effect while dropping
    tbl.push_back(mk(1, 3, 0, 3'b000, 0, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(1, 3, 0, 3'b000, 3'b111, 0, 0, S_DROP, 0, 3));
    tbl.push_back(mk(0, 3, 0, 3'b000, 0, 0, 0, S_IDLE, 0, 3));

    // Reset state
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset", S_IDLE, 0, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("idle_no_valid", S_IDLE, 0, 0);

    foreach (tbl[i]) begin
      pkt_valid = tbl[i].pv; data_in = tbl[i].din; fifo_full = tbl[i].ff;
      fifo_empty = tbl[i].fe; soft_reset = tbl[i].sr;
      parity_done = tbl[i].pd; low_pkt_valid = tbl[i].lpv;
      model_step();
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].to, tbl[i].dest);
    end

    // Asynchronous reset while stalled in FFS
    soft_reset = '0; parity_done = 0; low_pkt_valid = 0;
    pkt_valid = 1; data_in = 1; fifo_empty = 3'b010; fifo_full = 0;
    tick("async_lfd");
    tick("async_ld");
    fifo_full = 1;
    tick("async_ffs");
    #3 resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset", S_IDLE, 0, 0);
    pkt_valid = 0; fifo_full = 0;
    #2 resetn = 1'b1;

    // Randomised run against the model
    for (int c = 0; c < 3000; c++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = AW'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : '0;
      soft_reset    = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, 2)) : '0;
      parity_done   = ($urandom_range(0, 2) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 0);
      tick($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
- Parametrised successor to the 1x3 router control FSM. Sequences header decode, payload load, FIFO-full stall, parity load and parity check for one input stream routed to one of N output FIFOs.
- New relative to the fixed 1x3 controller:
  - N-channel vector interfaces.
  - A DROP state that discards packets with an out-of-range address.
  - A bounded wait-till-empty timeout that also drops the packet.
- Sits between the input register block and the synchronizer/FIFO bank.

Parameters:
- N, 3, number of output channels (2..16).
- ADDR_W, $clog2(N) (minimum 1), width of the header address field.
- WAIT_LIMIT, 16, maximum cycles spent in WAIT_TILL_EMPTY before drop; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  input packet byte valid.
- data_in  in  ADDR_W  address field of the header byte.
- fifo_full  in  1  selected FIFO full.
- fifo_empty  in  N  per-channel FIFO empty.
- soft_reset  in  N  per-channel soft reset from the synchronizer.
- parity_done  in  1  parity byte captured.
- low_pkt_valid  in  1  pkt_valid fell while stalled.
- detect_add  out  1  state==DA.
- lfd_state  out  1  state==LFD.
- ld_state  out  1  state==LD.
- laf_state  out  1  state==LAF.
- full_state  out  1  state==FFS.
- rst_int_reg  out  1  state==CPE.
- write_enb_reg  out  1  LD|LP|LAF.
- busy  out  1  high in LFD, WTE, FFS, LAF, LP, CPE; low in DA, LD, DROP.
- drop_state  out  1  state==DROP.
- dest_sel  out  ADDR_W  latched destination channel.
- wait_timeout  out  1  one-cycle pulse on timeout drop.

Behaviour:
- Clock and reset: single clock domain. resetn is asynchronous and active-low. Reset forces:
  - state=DA, dest_sel=0, wait_cnt=0, wait_timeout=0.
  - Hence detect_add=1 and all other outputs 0.
- State encoding: 4-bit, 9 states: DA, LFD, LD, WTE, CPE, LP, FFS, LAF, DROP.
- Outputs: all state flags are combinational decodes of the present state. dest_sel and wait_timeout are registered.
- DA, only when pkt_valid=1; dest_sel<=data_in on the same edge:
  - data_in>=N -> DROP.
  - Else if fifo_empty[data_in] -> LFD.
  - Else -> WTE.
  - With pkt_valid=0 the FSM stays in DA.
- LFD: -> LD unconditionally.
- LD, evaluated in priority order:
  - fifo_full -> FFS.
  - Else !pkt_valid -> LP.
  - Else stay in LD.
- FFS: !fifo_full -> LAF; else stay.
- LAF, evaluated in priority order:
  - parity_done -> DA.
  - Else low_pkt_valid -> LP.
  - Else -> LD.
- LP: -> CPE unconditionally.
- CPE: fifo_full -> FFS; else -> DA.
- WTE, evaluated in priority order:
  - fifo_empty[dest_sel] -> LFD.
  - Else WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT-1 -> DROP, with wait_timeout=1 on that edge.
  - Else stay and increment wait_cnt.
  - wait_cnt clears on every entry to WTE, so WTE lasts at most WAIT_LIMIT cycles.
  - Empty wins over a same-cycle timeout.
- DROP: !pkt_valid -> DA; else stay.
  - write_enb_reg=0 and busy=0, so bytes are consumed and discarded.
  - soft_reset is ignored in DROP.
- Soft reset: in any state except DA and DROP, soft_reset[dest_sel]=1 -> DA next cycle. This has priority over every other transition. Soft resets on other channels are ignored.
- wait_timeout: high for exactly the first cycle in DROP when DROP is entered from WTE. It is 0 for an address drop.
- Mid-operation reset: state returns to DA immediately (asynchronously); no packet state is retained.

Decomposition:
- Package router_pkg:
  - State enum and its 4-bit encoding.
  - Default N and WAIT_LIMIT constants.
  - ADDR_W helper function.
- One sub-module, router_wait_timer: a counter of width $clog2(WAIT_LIMIT+1).
  - Inputs: clear, enable.
  - Output: expired.
  - Instantiated only when WAIT_LIMIT!=0.

Test Plan:
- N=3, WAIT_LIMIT=16. Reset; pkt_valid=1, data_in=1, fifo_empty=3'b010; drop pkt_valid after 2 cycles.
  - Required sequence DA->LFD->LD->LD->LP->CPE->DA.
  - write_enb_reg=1 in LD and LP; rst_int_reg=1 in CPE only; dest_sel=1.
- Stall and resume: fifo_full=1 for 3 cycles while in LD, then 0 with low_pkt_valid=1, parity_done=0.
  - Required sequence LD->FFS(x3)->LAF->LP->CPE->DA.
  - full_state=1 for 3 cycles; busy=1 throughout the stall.
- Address drop: data_in=3 with N=3, pkt_valid high for 4 cycles.
  - DROP for 4 cycles, then DA.
  - write_enb_reg=0, busy=0, drop_state=1, wait_timeout=0.
- Wait timeout: WAIT_LIMIT=4, data_in=2, fifo_empty[2]=0 held.
  - WTE for exactly 4 cycles, then DROP.
  - wait_timeout=1 for one cycle; busy=1 in WTE.
- Empty/timeout race and soft reset:
  - fifo_empty[2] rises in WTE's 4th cycle -> LFD, no timeout pulse.
  - Later, soft_reset[2] during LD -> DA next cycle.
  - soft_reset[0] during LD -> ignored.
- Asynchronous reset mid-FFS: resetn low between clock edges -> detect_add=1 and full_state=0 before the next edge; dest_sel=0.
